// File: rtl/adc_sample_averager.sv
// -----------------------------------------------------------------------------
// adc_sample_averager
//   Block-averages a stream of SAR ADC samples. Every 2^LOG2_N accepted
//   samples are summed and the sum is truncated (shifted right by LOG2_N) into
//   a one-entry output register that a consumer drains with a valid/ready
//   handshake. A result that gets overwritten before it is accepted sets the
//   sticky overrun flag.
//
// Parameters
//   DATA_W         width of each sample and of the averaged result
//   LOG2_N         samples per average = 2^LOG2_N (legal range 0..8)
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   sample_i       conversion result
//   sample_valid_i one-cycle strobe per completed conversion
//   enable_i       high = accumulate, low = hold the block idle
//   clear_i        one-cycle pulse, clears overrun_o
//   avg_o          averaged result
//   avg_valid_o    avg_o holds an unconsumed result
//   avg_ready_i    consumer accepts avg_o when high together with avg_valid_o
//   overrun_o      sticky: a result was overwritten before acceptance
//   fill_o         samples accumulated in the current block
// -----------------------------------------------------------------------------
module adc_sample_averager #(
  parameter int DATA_W = 14,
  parameter int LOG2_N = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              enable_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_valid_o,
  input  logic              avg_ready_i,
  output logic              overrun_o,
  output logic [LOG2_N:0]   fill_o
);

  // LOG2_N extra bits hold the sum of 2^LOG2_N full-scale samples without wrap.
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic              overrun_q, overrun_d;

  logic [ACC_W-1:0]  sum;
  logic              take;
  logic              block_done;
  logic              accepted;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;

    sum        = acc_q + ACC_W'(sample_i);
    take       = sample_valid_i && enable_i;
    block_done = take && (cnt_q == CNT_LAST);
    accepted   = avg_valid_q && avg_ready_i;

    // Accumulator/counter: disabled means idle at zero, which also discards
    // any partial block when enable drops mid-block.
    if (!enable_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (block_done) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Output register: a new result always wins over acceptance of the old one.
    if (block_done) begin
      avg_d       = sum[LOG2_N +: DATA_W];
      avg_valid_d = 1'b1;
    end else if (accepted) begin
      avg_valid_d = 1'b0;
    end

    // Overrun only when the previous result is still pending and not being
    // accepted on this edge; a coincident clear loses to the set.
    if (block_done && avg_valid_q && !avg_ready_i) begin
      overrun_d = 1'b1;
    end else if (clear_i) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign overrun_o   = overrun_q;
  assign fill_o      = cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_averager
//   Three averager instances (LOG2_N = 1, 2, 4; DATA_W = 14) exercised one at a
//   time with directed vectors. Expected averages are pushed to a scoreboard
//   queue when the stimulus is issued; a monitor pops and compares whenever an
//   instance completes a valid/ready handshake. Side-band behaviour (latency,
//   fill, overrun, reset) is checked inline.
//   Index 0 -> LOG2_N=1, index 1 -> LOG2_N=2, index 2 -> LOG2_N=4.
// -----------------------------------------------------------------------------
module tb_adc_sample_averager;

  typedef struct {
    int          dut;
    logic [13:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] sample    [3];
  logic        valid     [3];
  logic        en        [3];
  logic        clr       [3];
  logic        rdy       [3];
  logic [13:0] avg       [3];
  logic        avg_valid [3];
  logic        ovr       [3];
  logic [1:0]  fill0;
  logic [2:0]  fill1;
  logic [4:0]  fill2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  adc_sample_averager #(.DATA_W(14), .LOG2_N(1)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .sample_i(sample[0]), .sample_valid_i(valid[0]),
    .enable_i(en[0]), .clear_i(clr[0]), .avg_o(avg[0]), .avg_valid_o(avg_valid[0]),
    .avg_ready_i(rdy[0]), .overrun_o(ovr[0]), .fill_o(fill0));

  adc_sample_averager #(.DATA_W(14), .LOG2_N(2)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .sample_i(sample[1]), .sample_valid_i(valid[1]),
    .enable_i(en[1]), .clear_i(clr[1]), .avg_o(avg[1]), .avg_valid_o(avg_valid[1]),
    .avg_ready_i(rdy[1]), .overrun_o(ovr[1]), .fill_o(fill1));

  adc_sample_averager #(.DATA_W(14), .LOG2_N(4)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .sample_i(sample[2]), .sample_valid_i(valid[2]),
    .enable_i(en[2]), .clear_i(clr[2]), .avg_o(avg[2]), .avg_valid_o(avg_valid[2]),
    .avg_ready_i(rdy[2]), .overrun_o(ovr[2]), .fill_o(fill2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int d, input logic [13:0] v);
    exp_t e;
    e.dut = d;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // One-cycle strobe, issued just after a rising edge and captured by the next.
  task automatic send(input int d, input logic [13:0] v);
    sample[d] = v;
    valid[d]  = 1'b1;
    @(posedge clk); #1;
    valid[d]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge when
  // valid and ready are both high mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!reset && avg_valid[i] && rdy[i]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_result dut%0d: got 0x%0h, expected none", i, avg[i]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.dut == i && avg[i] === e.val) n_pass++;
            else $display("FAIL scoreboard dut%0d: got 0x%0h, expected dut%0d 0x%0h",
                          i, avg[i], e.dut, e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample[i] = '0; valid[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0; rdy[i] = 1'b1;
    end
    idle(2);
    check("reset_avg",   32'(avg[1]),       32'h0);
    check("reset_valid", 32'(avg_valid[1]), 32'h0);
    check("reset_ovr",   32'(ovr[1]),       32'h0);
    check("reset_fill",  32'(fill1),        32'h0);
    reset = 1'b0;
    idle(1);

    // LOG2_N=2, ready high: 0x2FFF x4, valid exactly one clock later for one cycle
    en[1] = 1'b1;
    push(1, 14'h2FFF);
    for (int k = 0; k < 3; k++) send(1, 14'h2FFF);
    check("a_valid_early", 32'(avg_valid[1]), 32'h0);
    send(1, 14'h2FFF);
    check("a_valid_latency", 32'(avg_valid[1]), 32'h1);
    check("a_fill_wrap",     32'(fill1),        32'h0);
    idle(1);
    check("a_valid_one_cycle", 32'(avg_valid[1]), 32'h0);

    // Truncation and full scale
    push(1, 14'h0002);
    for (int k = 1; k <= 4; k++) send(1, 14'(k));
    push(1, 14'h3FFF);
    for (int k = 0; k < 4; k++) send(1, 14'h3FFF);
    idle(2);

    // Partial block discarded by one disabled cycle
    send(1, 14'd100);
    send(1, 14'd100);
    check("c_fill_partial", 32'(fill1), 32'h2);
    en[1] = 1'b0;
    idle(1);
    check("c_fill_discard", 32'(fill1), 32'h0);
    en[1] = 1'b1;
    push(1, 14'd8);
    for (int k = 0; k < 4; k++) send(1, 14'd8);
    idle(2);

    // LOG2_N=4: 16 full-scale samples, fill counts 0..15 then wraps
    en[2] = 1'b1;
    push(2, 14'h3FFF);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("d_fill_%0d", k), 32'(fill2), 32'(k));
      send(2, 14'h3FFF);
    end
    check("d_fill_wrap", 32'(fill2), 32'h0);
    idle(2);

    // LOG2_N=1, ready low: overwrite sets overrun, clear drops it, ready drains
    en[0]  = 1'b1;
    rdy[0] = 1'b0;
    send(0, 14'd2);
    send(0, 14'd4);
    check("e_avg_first", 32'(avg[0]), 32'd3);
    check("e_ovr_clean", 32'(ovr[0]), 32'h0);
    send(0, 14'd6);
    send(0, 14'd8);
    check("e_avg_overwrite", 32'(avg[0]),       32'd7);
    check("e_ovr_set",       32'(ovr[0]),       32'h1);
    check("e_valid_held",    32'(avg_valid[0]), 32'h1);
    idle(1);
    check("e_avg_stable", 32'(avg[0]), 32'd7);
    clr[0] = 1'b1;
    idle(1);
    clr[0] = 1'b0;
    check("e_ovr_cleared", 32'(ovr[0]),       32'h0);
    check("e_valid_kept",  32'(avg_valid[0]), 32'h1);
    push(0, 14'd7);
    rdy[0] = 1'b1;
    idle(1);
    check("e_valid_drained", 32'(avg_valid[0]), 32'h0);

    // Load coinciding with acceptance: stays valid with new value, no overrun
    rdy[0] = 1'b0;
    send(0, 14'd14);
    send(0, 14'd16);
    send(0, 14'd20);
    push(0, 14'd15);
    push(0, 14'd25);
    rdy[0] = 1'b1;
    send(0, 14'd30);
    check("f_valid_reload", 32'(avg_valid[0]), 32'h1);
    check("f_avg_reload",   32'(avg[0]),       32'd25);
    check("f_ovr_none",     32'(ovr[0]),       32'h0);
    idle(2);

    // Pending result drains while disabled; strobes ignored
    rdy[0] = 1'b0;
    send(0, 14'd1);
    send(0, 14'd3);
    en[0] = 1'b0;
    send(0, 14'd50);
    check("g_fill_idle", 32'(fill0), 32'h0);
    check("g_avg_held",  32'(avg[0]), 32'd2);
    push(0, 14'd2);
    rdy[0] = 1'b1;
    idle(2);
    check("g_valid_drained", 32'(avg_valid[0]), 32'h0);

    // Reset asserted between edges, mid-block, with a pending result and overrun
    rdy[1] = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 14'd9);
    check("h_avg_pre", 32'(avg[1]), 32'd9);
    for (int k = 0; k < 4; k++) send(1, 14'd3);
    check("h_ovr_pre", 32'(ovr[1]), 32'h1);
    send(1, 14'd50);
    send(1, 14'd50);
    check("h_fill_pre", 32'(fill1), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("h_rst_avg",   32'(avg[1]),       32'h0);
    check("h_rst_valid", 32'(avg_valid[1]), 32'h0);
    check("h_rst_ovr",   32'(ovr[1]),       32'h0);
    check("h_rst_fill",  32'(fill1),        32'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    rdy[1] = 1'b1;
    push(1, 14'd5);
    for (int k = 0; k < 4; k++) send(1, 14'd5);
    idle(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
